// File: rtl/sfx_sequencer.sv
// Multi-effect buzzer sequencer: scripted note playback with priority preemption,
// a one-deep pending slot, volume-scaled PWM duty and mute.
module sfx_sequencer #(
  parameter int CLK_HZ      = 100_000_000,
  parameter int STEP_CYCLES = 6_250_000,
  parameter int STEPS       = 48,
  parameter int CODE_W      = 3,
  parameter int VOL_BASE    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              play,
  input  logic [CODE_W-1:0] sound_code,
  input  logic [1:0]        volume,
  input  logic              mute,
  output logic              B,
  output logic              busy,
  output logic              done,
  output logic [CODE_W-1:0] cur_code
);

  localparam int SW = $clog2(STEPS + 1);
  localparam int TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int PW = $clog2(CLK_HZ / 440 + 1);
  localparam logic [SW-1:0] STEP_END   = SW'(STEPS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(STEP_CYCLES - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state_reg, state_next;
  logic [CODE_W-1:0] code_reg, code_next;
  logic [SW-1:0]     step_reg, step_next;
  logic [TW-1:0]     timer_reg, timer_next;
  logic              pend_valid_reg, pend_valid_next;
  logic [CODE_W-1:0] pend_code_reg, pend_code_next;
  logic [PW-1:0]     phase_reg, phase_next;
  logic              b_reg, b_next;
  logic              done_reg, done_next;

  logic              load, end_cycle, req_start;
  logic [4:0]        note_cur, note_next;
  logic [PW-1:0]     period_cur, high_cur;
  int                shift_amt;

  // Script steps past the last segment are silent, which also covers the end cycle.
  function automatic logic [4:0] script_note(input logic [CODE_W-1:0] code, input logic [SW-1:0] step);
    int s;
    s = int'(step);
    script_note = 5'd0;
    case (int'(code))
      1: script_note = (s < 8) ? 5'd13 : (s < 48) ? 5'd16 : 5'd0;
      2: script_note = (s < 8) ? 5'd16 : (s < 48) ? 5'd13 : 5'd0;
      3: script_note = (s < 16) ? 5'd15 : 5'd0;
      4: script_note = (s < 8) ? 5'd19 : (s < 16) ? 5'd16 : (s < 48) ? 5'd13 : 5'd0;
      5: script_note = (s < 24) ? 5'd6 : (s < 32) ? 5'd0 : (s < 48) ? 5'd6 : 5'd0;
      6: script_note = (s < 8) ? 5'd15 : (s < 16) ? 5'd17 : (s < 24) ? 5'd19 : (s < 48) ? 5'd20 : 5'd0;
      7: script_note = (s < 16) ? 5'd13 : (s < 32) ? 5'd11 : (s < 48) ? 5'd9 : 5'd0;
      default: script_note = 5'd0;
    endcase
  endfunction

  function automatic logic [PW-1:0] note_period(input logic [4:0] note);
    case (note)
      5'd6:    note_period = PW'(CLK_HZ / 440);
      5'd9:    note_period = PW'(CLK_HZ / 587);
      5'd11:   note_period = PW'(CLK_HZ / 698);
      5'd13:   note_period = PW'(CLK_HZ / 880);
      5'd15:   note_period = PW'(CLK_HZ / 1046);
      5'd16:   note_period = PW'(CLK_HZ / 1174);
      5'd17:   note_period = PW'(CLK_HZ / 1318);
      5'd19:   note_period = PW'(CLK_HZ / 1568);
      5'd20:   note_period = PW'(CLK_HZ / 1760);
      default: note_period = '0;
    endcase
  endfunction

  always_comb begin
    state_next      = state_reg;
    code_next       = code_reg;
    step_next       = step_reg;
    timer_next      = timer_reg;
    pend_valid_next = pend_valid_reg;
    pend_code_next  = pend_code_reg;
    done_next       = 1'b0;
    load            = 1'b0;
    end_cycle       = (state_reg == PLAY) && (step_reg == STEP_END);
    req_start       = play && (sound_code != '0);

    // The end cycle accepts a new start exactly like IDLE does.
    if (state_reg == IDLE || end_cycle) begin
      if (req_start) begin
        state_next      = PLAY;
        code_next       = sound_code;
        step_next       = '0;
        timer_next      = '0;
        pend_valid_next = 1'b0;
        load            = 1'b1;
      end else if (end_cycle) begin
        step_next  = '0;
        timer_next = '0;
        if (pend_valid_reg) begin
          state_next      = PLAY;
          code_next       = pend_code_reg;
          pend_valid_next = 1'b0;
          load            = 1'b1;
        end else begin
          state_next = IDLE;
          code_next  = '0;
        end
      end
    end else if (play && sound_code == '0) begin
      state_next      = IDLE;
      code_next       = '0;
      step_next       = '0;
      timer_next      = '0;
      pend_valid_next = 1'b0;
    end else if (play && sound_code > code_reg) begin
      code_next  = sound_code;
      step_next  = '0;
      timer_next = '0;
      load       = 1'b1;
    end else begin
      if (play) begin
        pend_valid_next = 1'b1;
        pend_code_next  = sound_code;
      end
      if (timer_reg == TIMER_LAST) begin
        timer_next = '0;
        step_next  = step_reg + SW'(1);
        done_next  = (step_next == STEP_END);
      end else begin
        timer_next = timer_reg + TW'(1);
      end
    end

    note_cur   = (state_reg == PLAY) ? script_note(code_reg, step_reg) : 5'd0;
    note_next  = (state_next == PLAY) ? script_note(code_next, step_next) : 5'd0;
    period_cur = note_period(note_cur);
    shift_amt  = VOL_BASE - 2 * int'(volume);
    high_cur   = period_cur >> shift_amt;

    // Phase restarts on every note boundary so each note opens with its high phase.
    if (load || note_next == 5'd0 || note_next != note_cur)
      phase_next = '0;
    else if (phase_reg == period_cur - PW'(1))
      phase_next = '0;
    else
      phase_next = phase_reg + PW'(1);

    b_next = (note_cur != 5'd0) && !mute && (phase_reg < high_cur);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= IDLE;
      code_reg       <= '0;
      step_reg       <= '0;
      timer_reg      <= '0;
      pend_valid_reg <= 1'b0;
      pend_code_reg  <= '0;
      phase_reg      <= '0;
      b_reg          <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      code_reg       <= code_next;
      step_reg       <= step_next;
      timer_reg      <= timer_next;
      pend_valid_reg <= pend_valid_next;
      pend_code_reg  <= pend_code_next;
      phase_reg      <= phase_next;
      b_reg          <= b_next;
      done_reg       <= done_next;
    end
  end

  assign B        = b_reg;
  assign busy     = (state_reg == PLAY);
  assign done     = done_reg;
  assign cur_code = code_reg;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Randomised and directed bench for sfx_sequencer, checked every cycle against a
// start-time based model of the effect scripts.
module tb_sfx_sequencer;

  localparam int CLK_HZ   = 1_000_000;
  localparam int SC       = 10;
  localparam int STEPS    = 48;
  localparam int VOL_BASE = 8;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       play = 1'b0;
  logic [2:0] sound_code = 3'd0;
  logic [1:0] volume = 2'd0;
  logic       mute = 1'b0;
  logic       B, busy, done;
  logic [2:0] cur_code;

  sfx_sequencer #(
    .CLK_HZ(CLK_HZ), .STEP_CYCLES(SC), .STEPS(STEPS), .CODE_W(3), .VOL_BASE(VOL_BASE)
  ) dut (
    .clk(clk), .rstn(rstn), .play(play), .sound_code(sound_code), .volume(volume),
    .mute(mute), .B(B), .busy(busy), .done(done), .cur_code(cur_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Effect scripts as (note, length-in-steps) segments.
  int seg_note [8][4] = '{'{0,0,0,0}, '{13,16,0,0}, '{16,13,0,0}, '{15,0,0,0},
                          '{19,16,13,0}, '{6,0,6,0}, '{15,17,19,20}, '{13,11,9,0}};
  int seg_len  [8][4] = '{'{0,0,0,0}, '{8,40,0,0}, '{8,40,0,0}, '{16,32,0,0},
                          '{8,8,32,0}, '{24,8,16,0}, '{8,8,8,24}, '{16,16,16,0}};

  // Model: an effect is described by its code and the cycle its step 0 began.
  bit m_on = 1'b0;
  int m_code = 0, m_start = 0, m_pc = 0, m_note_start = 0, cyc = 0;
  bit m_pv = 1'b0, m_b = 1'b0;
  int vol_cur = 0;
  bit mute_cur = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int note_at(int code, int step);
    int acc = 0;
    for (int i = 0; i < 4; i++) begin
      acc += seg_len[code][i];
      if (step < acc) return seg_note[code][i];
    end
    return 0;
  endfunction

  function automatic int period_of(int n);
    int f;
    case (n)
      6: f = 440;   9: f = 587;   11: f = 698;  13: f = 880;  15: f = 1046;
      16: f = 1174; 17: f = 1318; 19: f = 1568; 20: f = 1760;
      default: f = 0;
    endcase
    return (f == 0) ? 0 : CLK_HZ / f;
  endfunction

  function automatic int m_note(int t);
    if (!m_on) return 0;
    return note_at(m_code, (t - m_start) / SC);
  endfunction

  function automatic bit m_end(int t);
    return m_on && (t - m_start) == STEPS * SC;
  endfunction

  task automatic model_step(input bit p, input int c, input int v, input bit mu);
    int  n_now, q, ph;
    bit  endc, started;
    n_now   = m_note(cyc);
    q       = period_of(n_now);
    endc    = m_end(cyc);
    started = 1'b0;
    ph      = (q == 0) ? 0 : (cyc - m_note_start) % q;
    m_b     = (n_now != 0) && !mu && (ph < (q >> (VOL_BASE - 2 * v)));
    if (!m_on || endc) begin
      if (p && c != 0) begin
        m_on = 1'b1; m_code = c; m_start = cyc + 1; m_pv = 1'b0; started = 1'b1;
      end else if (endc) begin
        if (m_pv) begin
          m_code = m_pc; m_start = cyc + 1; m_pv = 1'b0; started = 1'b1;
        end else begin
          m_on = 1'b0;
        end
      end
    end else if (p && c == 0) begin
      m_on = 1'b0; m_pv = 1'b0;
    end else if (p && c > m_code) begin
      m_code = c; m_start = cyc + 1; started = 1'b1;
    end else if (p) begin
      m_pv = 1'b1; m_pc = c;
    end
    cyc++;
    if (started || m_note(cyc) != n_now) m_note_start = cyc;
  endtask

  task automatic tick(input bit p, input int c, input int v, input bit mu);
    @(negedge clk);
    check("busy", busy, 32'(m_on));
    check("cur_code", cur_code, m_on ? m_code : 0);
    check("done", done, 32'(m_end(cyc)));
    check("B", B, 32'(m_b));
    play = p; sound_code = c[2:0]; volume = v[1:0]; mute = mu;
    if (p) $display("cycle %0d: play code=%0d vol=%0d mute=%0d", cyc, c, v, mu);
    model_step(p, c, v, mu);
  endtask

  task automatic run(input int k);
    repeat (k) tick(1'b0, 0, vol_cur, mute_cur);
  endtask

  task automatic run_to_end();
    for (int g = 0; g < 1000 && !m_end(cyc); g++) tick(1'b0, 0, vol_cur, mute_cur);
  endtask

  initial begin
    int n;
    #2;
    check("rst_B", B, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_code", cur_code, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Single effect end to end, done latency from first busy cycle.
    tick(1'b1, 1, 0, 1'b0);
    n = 0;
    for (int g = 0; g < 1000; g++) begin
      tick(1'b0, 0, 0, 1'b0);
      if (done === 1'b1) break;
      n++;
    end
    check("t1_done_lat", n, 480);
    run(5);

    // Preempt at step 5 by higher code, then stop with code 0.
    tick(1'b1, 3, 0, 1'b0);
    run(50);
    tick(1'b1, 4, 0, 1'b0);
    run(100);
    tick(1'b1, 0, 0, 1'b0);
    run(3);

    // Pending slot: lower requests queue, last one wins, plays back-to-back.
    tick(1'b1, 7, 0, 1'b0);
    run(20);
    tick(1'b1, 2, 0, 1'b0);
    run(5);
    tick(1'b1, 5, 0, 1'b0);
    run_to_end();
    run(500);

    // Volume 3 then mute mid-effect; timing of steps must not change.
    vol_cur = 3;
    tick(1'b1, 1, vol_cur, 1'b0);
    run(30);
    mute_cur = 1'b1;
    run(100);
    mute_cur = 1'b0;
    run(400);
    vol_cur = 1;

    // Request on the end cycle starts even a lower code and overrides pending.
    tick(1'b1, 5, vol_cur, 1'b0);
    tick(1'b1, 2, vol_cur, 1'b0);
    run_to_end();
    tick(1'b1, 4, vol_cur, 1'b0);
    run_to_end();
    tick(1'b1, 3, vol_cur, 1'b0);
    run(3);

    // Asynchronous reset in the middle of an effect.
    tick(1'b1, 6, vol_cur, 1'b0);
    run(100);
    #2 rstn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_B", B, 0);
    check("arst_done", done, 0);
    check("arst_code", cur_code, 0);
    m_on = 1'b0; m_pv = 1'b0; m_b = 1'b0; m_note_start = cyc;
    play = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 12000; i++) begin
      bit p;
      int c;
      if ($urandom_range(0, 499) == 0) vol_cur = $urandom_range(0, 3);
      if ($urandom_range(0, 799) == 0) mute_cur = !mute_cur;
      p = ($urandom_range(0, 149) == 0);
      c = $urandom_range(0, 7);
      tick(p, c, vol_cur, mute_cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
